framebuf_sched: RTL and testbench

Double-buffered frame memory controller for the LED string driver. Owns two banks of `c_channels` × `c_bps` channel values and routes accesses to them. The host-side loader writes the back bank while the driver reads the front bank. Bank swaps happen only at a frame boundary, so a latched frame never mixes old and new data. It sits between the host loader (UART/SPI deframer) and the driver's `o_addr`/`i_data` pair.

---
 rtl/framebuf_sched.sv | 141 ++++++++++++++
 tb/tb_framebuf_sched.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/framebuf_sched.sv
// framebuf_sched: double-buffered LED frame memory. The host fills the back bank while the driver reads the front bank; banks swap only at a frame boundary.
// Optional macro FRAMEBUF_BRIGHTNESS_EN scales read data by i_brightness/256 after the read register.
module framebuf_sched #(
    parameter int c_ledboards = 30,
    parameter int c_channels  = c_ledboards * 32,
    parameter int c_addr_w    = $clog2(c_channels),
    parameter int c_bps       = 12
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [c_addr_w-1:0] i_rd_addr,
    output logic [c_bps-1:0]    o_rd_data,
    input  logic                i_frame_start,
    input  logic                i_wr_valid,
    input  logic [c_addr_w-1:0] i_wr_addr,
    input  logic [c_bps-1:0]    i_wr_data,
    output logic                o_wr_ready,
    input  logic                i_commit,
    input  logic                i_clear,
    output logic                o_pending,
    output logic                o_swapped,
    output logic                o_front,
    input  logic [7:0]          i_brightness
);

    // state   | meaning
    // s_fill  | back bank open for host writes
    // s_clear | zeroing the back bank, one address per cycle
    // s_pend  | commit waiting for the next frame boundary
    // s_swap  | single cycle after the bank swap
    typedef enum logic [1:0] {
        s_fill  = 2'd0,
        s_clear = 2'd1,
        s_pend  = 2'd2,
        s_swap  = 2'd3
    } state_t;

    localparam logic [c_addr_w:0]   c_lim  = (c_addr_w + 1)'(c_channels);
    localparam logic [c_addr_w-1:0] c_last = c_addr_w'(c_channels - 1);

    state_t                r_state;
    state_t                n_state;
    logic                  r_front;
    logic [c_addr_w-1:0]   r_clr;
    logic [c_bps-1:0]      r_rd;
    logic                  mem_we;
    logic [c_addr_w-1:0]   mem_addr;
    logic [c_bps-1:0]      mem_wdata;
    logic                  swap_go;
    logic                  wr_in_range;
    logic                  rd_in_range;

    logic [c_bps-1:0] mem [2][c_channels];

    assign wr_in_range = ({1'b0, i_wr_addr} < c_lim);
    assign rd_in_range = ({1'b0, i_rd_addr} < c_lim);

    always_comb begin
        n_state   = r_state;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        swap_go   = 1'b0;
        unique case (r_state)
            s_fill: begin
                if (i_wr_valid && wr_in_range) begin
                    mem_we    = 1'b1;
                    mem_addr  = i_wr_addr;
                    mem_wdata = i_wr_data;
                end
                if (i_clear) begin
                    n_state = s_clear;
                end else if (i_commit) begin
                    n_state = s_pend;
                end
            end
            s_clear: begin
                mem_we   = 1'b1;
                mem_addr = r_clr;
                if (r_clr == c_last) begin
                    n_state = s_fill;
                end
            end
            s_pend: begin
                if (i_frame_start) begin
                    swap_go = 1'b1;
                    n_state = s_swap;
                end
            end
            s_swap: begin
                n_state = s_fill;
            end
            default: begin
                n_state = s_fill;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= s_fill;
            r_front <= 1'b0;
            r_clr   <= '0;
            r_rd    <= '0;
        end else begin
            r_state <= n_state;
            if (swap_go) begin
                r_front <= ~r_front;
            end
            if ((r_state == s_clear) && (r_clr != c_last)) begin
                r_clr <= r_clr + c_addr_w'(1);
            end else begin
                r_clr <= '0;
            end
            // Uses the pre-swap r_front, so a read on the swap edge still sees the old bank.
            r_rd <= rd_in_range ? mem[r_front][i_rd_addr] : '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (mem_we && !i_rst) begin
            mem[~r_front][mem_addr] <= mem_wdata;
        end
    end

    assign o_wr_ready = (r_state == s_fill);
    assign o_pending  = (r_state == s_pend);
    assign o_swapped  = (r_state == s_swap);
    assign o_front    = r_front;

`ifdef FRAMEBUF_BRIGHTNESS_EN
    logic [c_bps+7:0] scaled;
    assign scaled    = (c_bps + 8)'(r_rd) * (c_bps + 8)'(i_brightness);
    assign o_rd_data = scaled[c_bps+7:8];
`else
    logic unused_brightness;
    assign unused_brightness = ^i_brightness;
    assign o_rd_data = r_rd;
`endif

endmodule

// File: tb/tb_framebuf_sched.sv
// tb_framebuf_sched: directed stimulus with a read-data scoreboard for framebuf_sched.
// Works with or without FRAMEBUF_BRIGHTNESS_EN; expected read values are scaled accordingly.
module tb_framebuf_sched;

    localparam int CH  = 960;
    localparam int AW  = 10;
    localparam int BPS = 12;

    logic           i_clk = 1'b0;
    logic           i_rst = 1'b1;
    logic [AW-1:0]  i_rd_addr = '0;
    logic [BPS-1:0] o_rd_data;
    logic           i_frame_start = 1'b0;
    logic           i_wr_valid = 1'b0;
    logic [AW-1:0]  i_wr_addr = '0;
    logic [BPS-1:0] i_wr_data = '0;
    logic           o_wr_ready;
    logic           i_commit = 1'b0;
    logic           i_clear = 1'b0;
    logic           o_pending;
    logic           o_swapped;
    logic           o_front;
    logic [7:0]     i_brightness = 8'd255;

    int total = 0;
    int bad   = 0;

    logic rd_req    = 1'b0;
    logic rd_pend_q = 1'b0;
    int   exp_q[$];

    framebuf_sched dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_rd_addr    (i_rd_addr),
        .o_rd_data    (o_rd_data),
        .i_frame_start(i_frame_start),
        .i_wr_valid   (i_wr_valid),
        .i_wr_addr    (i_wr_addr),
        .i_wr_data    (i_wr_data),
        .o_wr_ready   (o_wr_ready),
        .i_commit     (i_commit),
        .i_clear      (i_clear),
        .o_pending    (o_pending),
        .o_swapped    (o_swapped),
        .o_front      (o_front),
        .i_brightness (i_brightness)
    );

    always #5 i_clk = ~i_clk;

    function automatic int scale(input int v);
`ifdef FRAMEBUF_BRIGHTNESS_EN
        return (v * int'(i_brightness)) >> 8;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge i_clk);
        rd_req = 1'b0;
    endtask

    task automatic issue_rd(input int addr, input int exp);
        i_rd_addr = AW'(addr);
        rd_req    = 1'b1;
        exp_q.push_back(exp);
    endtask

    task automatic wr(input int addr, input int data);
        i_wr_valid = 1'b1;
        i_wr_addr  = AW'(addr);
        i_wr_data  = BPS'(data);
        chk("wr_ready_on_write", int'(o_wr_ready), 1);
        tick();
        i_wr_valid = 1'b0;
    endtask

    task automatic commit();
        i_commit = 1'b1;
        tick();
        i_commit = 1'b0;
        chk("pending_after_commit", int'(o_pending), 1);
        chk("ready_low_in_pend", int'(o_wr_ready), 0);
    endtask

    task automatic do_swap(input int exp_front);
        i_frame_start = 1'b1;
        tick();
        i_frame_start = 1'b0;
        chk("swapped_pulse", int'(o_swapped), 1);
        chk("front_after_swap", int'(o_front), exp_front);
        chk("ready_low_in_swap", int'(o_wr_ready), 0);
        tick();
        chk("swapped_one_cycle", int'(o_swapped), 0);
        chk("ready_back_after_swap", int'(o_wr_ready), 1);
    endtask

    task automatic do_clear(input logic with_commit);
        int cnt;
        int pend_seen;
        i_clear  = 1'b1;
        i_commit = with_commit;
        tick();
        i_clear  = 1'b0;
        i_commit = 1'b0;
        cnt = 0;
        pend_seen = 0;
        while (!o_wr_ready && cnt < 2000) begin
            if (o_pending) pend_seen = 1;
            cnt++;
            tick();
        end
        chk("clear_cycles", cnt, CH);
        chk("no_pending_during_clear", pend_seen, 0);
    endtask

    always @(posedge i_clk) rd_pend_q <= rd_req;

    always @(negedge i_clk) begin
        if (rd_pend_q) begin
            if (exp_q.size() == 0) begin
                chk("rd_unexpected", int'(o_rd_data), -1);
            end else begin
                chk("rd_data", int'(o_rd_data), exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int errs;
        repeat (3) tick();
        i_rst = 1'b0;
        tick();
        chk("rst_front", int'(o_front), 0);
        chk("rst_ready", int'(o_wr_ready), 1);
        chk("rst_rd_data", int'(o_rd_data), 0);
        chk("rst_pending", int'(o_pending), 0);
        chk("rst_swapped", int'(o_swapped), 0);

        // zero bank 1, swap, then zero bank 0 with a colliding commit
        do_clear(1'b0);
        commit();
        do_swap(1);
        do_clear(1'b1);
        chk("clear_commit_no_pend", int'(o_pending), 0);

        wr(5, 'hABC);
        commit();
        issue_rd(5, 0);
        tick();
        issue_rd(5, 0);
        i_frame_start = 1'b1;
        tick();
        i_frame_start = 1'b0;
        chk("swap_front", int'(o_front), 0);
        chk("swap_pulse", int'(o_swapped), 1);
        issue_rd(5, scale('hABC));
        tick();
        chk("swap_pulse_done", int'(o_swapped), 0);
        chk("swap_ready", int'(o_wr_ready), 1);

        // commit held without a frame boundary: nothing may land
        commit();
        errs = 0;
        i_wr_valid = 1'b1;
        i_wr_addr  = AW'(7);
        i_wr_data  = BPS'('h555);
        repeat (1000) begin
            if (o_wr_ready || o_front != 1'b0 || !o_pending) errs++;
            tick();
        end
        i_wr_valid = 1'b0;
        chk("pend_hold_errs", errs, 0);
        do_swap(1);
        issue_rd(7, 0);
        tick();
        issue_rd(5, 0);
        tick();

        wr(0, 'h321);
        wr(CH, 'h123);
        commit();
        do_swap(0);
        issue_rd(0, scale('h321));
        tick();
        issue_rd(CH, 0);
        tick();
        issue_rd(5, scale('hABC));
        tick();
        issue_rd(1023, 0);
        tick();

        i_frame_start = 1'b1;
        tick();
        i_frame_start = 1'b0;
        chk("fs_in_fill_front", int'(o_front), 0);
        chk("fs_in_fill_swapped", int'(o_swapped), 0);

        // reset in the middle of a clear of bank 0
        commit();
        do_swap(1);
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        repeat (10) tick();
        chk("mid_clear_ready", int'(o_wr_ready), 0);
        i_rst = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
        chk("rst2_front", int'(o_front), 0);
        chk("rst2_ready", int'(o_wr_ready), 1);
        chk("rst2_pending", int'(o_pending), 0);
        chk("rst2_rd_data", int'(o_rd_data), 0);
        issue_rd(0, 0);
        tick();
        issue_rd(5, 0);
        tick();

        wr(9, 4095);
        commit();
        do_swap(1);
        i_brightness = 8'd128;
        issue_rd(9, scale(4095));
        tick();
        tick();
        i_brightness = 8'd0;
        issue_rd(9, scale(4095));
        tick();
        tick();
        i_brightness = 8'd255;

        repeat (3) tick();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
